// File: rtl/ctrl_pkg.sv
// Shared definitions for the direction/hold control stage: debounce state
// encoding, output reset values and default debounce length.
package ctrl_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } db_state_t;

    localparam logic CONTROL_RST   = 1'b1;
    localparam logic ENABLE_RST    = 1'b1;
    localparam int   DB_CYCLES_DEF = 4;
    localparam int   DB_W_DEF      = 8;

    // True once the counted run of disagreeing samples reaches the limit.
    function automatic logic db_done(input logic [7:0] cnt, input logic [7:0] last);
        return (cnt >= last);
    endfunction

endpackage : ctrl_pkg

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a four-state debounce FSM for one
// push button; 'rise' flags the edge on which the stable level goes high.
module btn_debounce
    import ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = DB_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    // The sample that leaves S_LOW/S_HIGH is the first of the run, so the
    // flip happens when the count shows DB_CYCLES-1 further agreeing samples.
    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] ONE  = DB_W'(1);

    logic            sync1_r;
    logic            sync2_r;
    db_state_t       state_r;
    db_state_t       state_s;
    logic [DB_W-1:0] cnt_r;
    logic [DB_W-1:0] cnt_s;
    logic            stable_r;
    logic            stable_s;
    logic            rise_s;
    logic            done_s;

    assign done_s = db_done(8'(cnt_r), 8'(LAST));

    // Synchroniser chain for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state, counter and stable-level logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        stable_s = stable_r;
        rise_s   = 1'b0;
        case (state_r)
            S_LOW: begin
                if (sync2_r) begin
                    cnt_s   = ONE;
                    state_s = S_RISE;
                end else begin
                    cnt_s   = '0;
                end
            end
            S_RISE: begin
                if (!sync2_r) begin
                    cnt_s   = '0;
                    state_s = S_LOW;
                end else if (done_s) begin
                    stable_s = 1'b1;
                    cnt_s    = '0;
                    state_s  = S_HIGH;
                    rise_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            S_HIGH: begin
                if (!sync2_r) begin
                    cnt_s   = ONE;
                    state_s = S_FALL;
                end else begin
                    cnt_s   = '0;
                end
            end
            S_FALL: begin
                if (sync2_r) begin
                    cnt_s   = '0;
                    state_s = S_HIGH;
                end else if (done_s) begin
                    stable_s = 1'b0;
                    cnt_s    = '0;
                    state_s  = S_LOW;
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            default: begin
                state_s  = S_LOW;
                cnt_s    = '0;
                stable_s = 1'b0;
            end
        endcase
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_LOW;
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            stable_r <= stable_s;
        end
    end

    assign stable = stable_r;
    assign rise   = rise_s;

endmodule : btn_debounce

// File: rtl/dir_ctrl.sv
// Direction/hold control for the up/down counter: each debounced button
// press toggles its registered output and emits a one-cycle strobe.
module dir_ctrl
    import ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = DB_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_dir,
    input  logic btn_hold,
    output logic control,
    output logic enable,
    output logic dir_pulse,
    output logic hold_pulse
);

    logic dir_stable_s;
    logic dir_rise_s;
    logic hold_stable_s;
    logic hold_rise_s;
    logic dir_toggle_s;
    logic hold_toggle_s;
    logic control_r;
    logic control_s;
    logic enable_r;
    logic enable_s;
    logic dir_pulse_r;
    logic hold_pulse_r;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_dir (
        .clk    (clk),
        .reset  (reset),
        .raw    (btn_dir),
        .stable (dir_stable_s),
        .rise   (dir_rise_s)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_hold (
        .clk    (clk),
        .reset  (reset),
        .raw    (btn_hold),
        .stable (hold_stable_s),
        .rise   (hold_rise_s)
    );

    // A rise can only come from a low stable level; the guard keeps that explicit.
    always_comb begin
        dir_toggle_s  = dir_rise_s & ~dir_stable_s;
        hold_toggle_s = hold_rise_s & ~hold_stable_s;
        if (dir_toggle_s) begin
            control_s = ~control_r;
        end else begin
            control_s = control_r;
        end
        if (hold_toggle_s) begin
            enable_s = ~enable_r;
        end else begin
            enable_s = enable_r;
        end
    end

    // Output toggle and strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control_r    <= CONTROL_RST;
            enable_r     <= ENABLE_RST;
            dir_pulse_r  <= 1'b0;
            hold_pulse_r <= 1'b0;
        end else begin
            control_r    <= control_s;
            enable_r     <= enable_s;
            dir_pulse_r  <= dir_toggle_s;
            hold_pulse_r <= hold_toggle_s;
        end
    end

    assign control    = control_r;
    assign enable     = enable_r;
    assign dir_pulse  = dir_pulse_r;
    assign hold_pulse = hold_pulse_r;

endmodule : dir_ctrl
